// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: redirect, ICache request/response and the decoded-pair output
// toward the decode buffer.
interface fetch_ctrl_if;
  logic        flush_BR;
  logic [31:0] i_br_target;
  logic        i_is_full;
  logic        stall_ICache;
  logic [31:0] i_IR1;
  logic [31:0] i_IR2;

  logic        o_fetch_req;
  logic [31:0] o_fetch_addr;
  logic [31:0] o_PC1;
  logic [31:0] o_IR1;
  logic [31:0] o_PC2;
  logic [31:0] o_IR2;
  logic [1:0]  o_is_valid;
  logic [1:0]  o_state;
  logic [31:0] o_fetch_cnt;

  modport master (
    input  flush_BR, i_br_target, i_is_full, stall_ICache, i_IR1, i_IR2,
    output o_fetch_req, o_fetch_addr, o_PC1, o_IR1, o_PC2, o_IR2, o_is_valid, o_state,
           o_fetch_cnt
  );

  modport slave (
    output flush_BR, i_br_target, i_is_full, stall_ICache, i_IR1, i_IR2,
    input  o_fetch_req, o_fetch_addr, o_PC1, o_IR1, o_PC2, o_IR2, o_is_valid, o_state,
           o_fetch_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues aligned pair fetches to the ICache, handles
// miss/backpressure/redirect and hands fetched instructions to decode one cycle later.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StMiss = 2'd2,
    StHold = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pc1_q;
  logic [31:0] ir1_q;
  logic [31:0] pc2_q;
  logic [31:0] ir2_q;
  logic [1:0]  valid_q;
  logic [31:0] cnt_q;

  logic        fetch_req;
  logic        fire;
  logic [31:0] redirect_pc;

  // Only RUN and MISS may request; a redirect or full buffer blocks the request outright.
  assign fetch_req   = ((state_q == StRun) || (state_q == StMiss)) &&
                       !bus.flush_BR && !bus.i_is_full;
  assign fire        = fetch_req && !bus.stall_ICache;
  assign redirect_pc = {bus.i_br_target[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      pc1_q   <= 32'd0;
      ir1_q   <= 32'd0;
      pc2_q   <= 32'd0;
      ir2_q   <= 32'd0;
      valid_q <= 2'b00;
      cnt_q   <= 32'd0;
    end else begin
      valid_q <= 2'b00;

      if (fire) begin
        pc1_q <= pc_q;
        ir1_q <= bus.i_IR1;
        // An odd-word pc only has its own slot left in the aligned pair.
        if (pc_q[2]) begin
          valid_q <= 2'b10;
          pc_q    <= pc_q + 32'd4;
          cnt_q   <= cnt_q + 32'd1;
        end else begin
          pc2_q   <= pc_q + 32'd4;
          ir2_q   <= bus.i_IR2;
          valid_q <= 2'b11;
          pc_q    <= pc_q + 32'd8;
          cnt_q   <= cnt_q + 32'd2;
        end
      end

      unique case (state_q)
        StBoot: state_q <= StRun;
        StRun, StMiss: begin
          if (bus.flush_BR) begin
            state_q <= StRun;
            pc_q    <= redirect_pc;
          end else if (bus.i_is_full) begin
            state_q <= StHold;
          end else if (bus.stall_ICache) begin
            state_q <= StMiss;
          end else begin
            state_q <= StRun;
          end
        end
        StHold: begin
          if (bus.flush_BR) begin
            state_q <= StRun;
            pc_q    <= redirect_pc;
          end else if (!bus.i_is_full) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StBoot;
      endcase
    end
  end

  assign bus.o_fetch_req  = fetch_req;
  assign bus.o_fetch_addr = pc_q;
  assign bus.o_PC1        = pc1_q;
  assign bus.o_IR1        = ir1_q;
  assign bus.o_PC2        = pc2_q;
  assign bus.o_IR2        = ir2_q;
  assign bus.o_is_valid   = valid_q;
  assign bus.o_state      = state_q;
  assign bus.o_fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a cycle model queues each expected decode-side
// result when inputs are driven; it is popped and compared after the clock edge.
module tb_fetch_ctrl;

  localparam logic [31:0] ResetPc = 32'h1C00_0000;

  logic clk;
  logic rst;
  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  valid;
    logic [31:0] pc1;
    logic [31:0] ir1;
    logic [31:0] pc2;
    logic [31:0] ir2;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [1:0]  m_state;
  logic [31:0] m_pc;
  exp_t        m_out;
  bit          m_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ir_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  task automatic step(input bit r, input bit fl, input logic [31:0] tgt, input bit full,
                      input bit st);
    bit   req;
    bit   fire;
    exp_t e;
    @(negedge clk);
    rst              = r;
    bus.flush_BR     = fl;
    bus.i_br_target  = tgt;
    bus.i_is_full    = full;
    bus.stall_ICache = st;
    bus.i_IR1        = ir_of(m_pc);
    bus.i_IR2        = ir_of(m_pc + 32'd4);
    #1;
    req  = m_known && (m_state == 2'd1 || m_state == 2'd2) && !fl && !full;
    fire = req && !st;
    if (m_known) begin
      check_eq("state", {30'd0, bus.o_state}, {30'd0, m_state});
      check_eq("fetch_addr", bus.o_fetch_addr, m_pc);
      check_eq("fetch_req", {31'd0, bus.o_fetch_req}, {31'd0, req});
    end
    if (r) begin
      m_state = 2'd0;
      m_pc    = ResetPc;
      m_out   = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_out.valid = 2'b00;
      if (fire) begin
        m_out.pc1 = m_pc;
        m_out.ir1 = bus.i_IR1;
        if (m_pc[2]) begin
          m_out.valid = 2'b10;
          m_out.cnt   = m_out.cnt + 32'd1;
          m_pc        = m_pc + 32'd4;
        end else begin
          m_out.valid = 2'b11;
          m_out.pc2   = m_pc + 32'd4;
          m_out.ir2   = bus.i_IR2;
          m_out.cnt   = m_out.cnt + 32'd2;
          m_pc        = m_pc + 32'd8;
        end
      end
      if (m_state == 2'd0) begin
        m_state = 2'd1;
      end else if (fl) begin
        m_state = 2'd1;
        m_pc    = {tgt[31:2], 2'b00};
      end else if (m_state == 2'd3) begin
        m_state = full ? 2'd3 : 2'd1;
      end else if (full) begin
        m_state = 2'd3;
      end else if (st) begin
        m_state = 2'd2;
      end else begin
        m_state = 2'd1;
      end
    end
    if (m_known) sb_q.push_back(m_out);
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check_eq("is_valid", {30'd0, bus.o_is_valid}, {30'd0, e.valid});
      check_eq("pc1", bus.o_PC1, e.pc1);
      check_eq("ir1", bus.o_IR1, e.ir1);
      check_eq("pc2", bus.o_PC2, e.pc2);
      check_eq("ir2", bus.o_IR2, e.ir2);
      check_eq("fetch_cnt", bus.o_fetch_cnt, e.cnt);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush_BR     = 1'b0;
    bus.i_br_target  = 32'd0;
    bus.i_is_full    = 1'b0;
    bus.stall_ICache = 1'b0;
    bus.i_IR1        = 32'd0;
    bus.i_IR2        = 32'd0;
    m_state          = 2'd0;
    m_pc             = ResetPc;
    m_out            = '0;

    // Reset, then boot and the first pair
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("rst_cnt_const", bus.o_fetch_cnt, 32'd0);
    idle(2);
    check_eq("boot_pc1_const", bus.o_PC1, 32'h1C00_0000);
    check_eq("boot_pc2_const", bus.o_PC2, 32'h1C00_0004);
    check_eq("boot_cnt_const", bus.o_fetch_cnt, 32'd2);
    idle(2);

    // Redirect to a misaligned target: single then pair
    step(1'b0, 1'b1, 32'h1C00_0106, 1'b0, 1'b0);
    idle(1);
    check_eq("redir_valid_const", {30'd0, bus.o_is_valid}, 32'd2);
    check_eq("redir_pc1_const", bus.o_PC1, 32'h1C00_0104);
    idle(2);

    // Three-cycle ICache miss at 0x1C000010
    step(1'b0, 1'b1, 32'h1C00_0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    idle(2);

    // Backpressure into HOLD, then release
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    idle(2);

    // All three in HOLD: the redirect wins
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'h1C00_0200, 1'b1, 1'b1);
    idle(2);

    // Reset in the middle of a miss, with a redirect attempted during BOOT
    step(1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1, 1'b1);
    check_eq("rst_miss_addr_const", bus.o_fetch_addr, ResetPc);
    step(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b0);
    idle(2);

    // Wrap at the top of the address space
    step(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0, 1'b0);
    idle(1);
    check_eq("wrap_pc2_const", bus.o_PC2, 32'hFFFF_FFFC);
    check_eq("wrap_addr_const", bus.o_fetch_addr, 32'h0000_0000);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 97) == 0, ($urandom % 8) == 0, $urandom, ($urandom % 5) == 0,
           ($urandom % 4) == 0);
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk drives every register, and rst is a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h1C00_0000, SHALL be the first fetch address after reset.
REQ-003 Port clk, input, 1: clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-high reset.
REQ-005 Port flush_BR, input, 1: branch redirect request.
REQ-006 Port i_br_target, input, 32: redirect address; valid only when flush_BR=1.
REQ-007 Port i_is_full, input, 1: backpressure from the decode buffer.
REQ-008 Port stall_ICache, input, 1: ICache miss, meaning i_IR1/i_IR2 are not valid this cycle.
REQ-009 Ports i_IR1 and i_IR2, input, 32 each: instructions at o_fetch_addr and o_fetch_addr+4, same cycle.
REQ-010 Port o_fetch_req, output, 1: fetch request to the ICache.
REQ-011 Port o_fetch_addr, output, 32: fetch address; always equals pc_q.
REQ-012 Ports o_PC1, o_IR1, o_PC2, o_IR2, output, 32 each: fetched pair driven to the decode buffer.
REQ-013 Port o_is_valid, output, 2: pair validity; 11 = both valid, 10 = first valid only, 00 = none.
REQ-014 Port o_state, output, 2: current state; BOOT=0, RUN=1, MISS=2, HOLD=3.
REQ-015 Port o_fetch_cnt, output, 32: count of delivered instructions.

Function
REQ-016 The state machine SHALL have the four states BOOT, RUN, MISS and HOLD.
REQ-017 o_fetch_req SHALL be combinational: (state is RUN or MISS) and flush_BR=0 and i_is_full=0.
REQ-018 A fetch fires in any cycle with o_fetch_req=1 and stall_ICache=0.
REQ-019 On a fire with pc_q[2]=0, the next cycle SHALL show o_PC1=pc_q, o_IR1=i_IR1, o_PC2=pc_q+4, o_IR2=i_IR2, o_is_valid=11, and pc_q SHALL advance by 8.
REQ-020 On a fire with pc_q[2]=1, the next cycle SHALL show o_PC1=pc_q, o_IR1=i_IR1, o_is_valid=10, and pc_q SHALL advance by 4; o_PC2 and o_IR2 SHALL hold their values.
REQ-021 In any cycle without a fire, o_is_valid SHALL be 00 the next cycle and o_PC*/o_IR* SHALL hold; latency from fire to valid output is exactly 1 cycle.
REQ-022 pc arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFF8 advances to 32'h0000_0000.
REQ-023 BOOT SHALL go to RUN unconditionally after one cycle, with no request issued.
REQ-024 From RUN or MISS, transitions SHALL follow this priority: flush_BR goes to RUN; otherwise i_is_full goes to HOLD; otherwise o_fetch_req with stall_ICache goes to MISS; otherwise RUN.
REQ-025 In MISS, o_fetch_addr SHALL stay unchanged until a fire occurs.
REQ-026 In HOLD, flush_BR SHALL go to RUN; i_is_full=0 SHALL go to RUN; otherwise the block stays in HOLD with pc_q held.
REQ-027 flush_BR=1 in any non-BOOT state SHALL load pc_q with {i_br_target[31:2],2'b00}, suppress any fire that cycle, and give o_is_valid=00 the next cycle.
REQ-028 flush_BR in BOOT SHALL be ignored.
REQ-029 When flush_BR, stall_ICache and i_is_full are asserted together, flush_BR SHALL win.
REQ-030 o_fetch_cnt SHALL increase by 2 on a pair fire and by 1 on a single fire, wrapping modulo 2^32; flush SHALL NOT clear it.

Reset
REQ-031 rst=1 at a clock edge SHALL set state=BOOT, pc_q=RESET_PC, o_is_valid=00, o_PC1=o_IR1=o_PC2=o_IR2=0 and o_fetch_cnt=0.
REQ-032 rst SHALL override flush_BR, stall_ICache and i_is_full, including mid-MISS or mid-HOLD.
REQ-033 During reset and BOOT, o_fetch_req SHALL be 0.

Verification
REQ-034 Release rst with no stalls -> cycle 1 BOOT with req=0; cycle 2 fetch 0x1C000000; cycle 3 o_PC1=0x1C000000, o_PC2=0x1C000004, o_is_valid=11, o_fetch_cnt=2.
REQ-035 Flush with target 0x1C000106 -> next fetch addr 0x1C000104 with valid 10, then 0x1C000108 with valid 11.
REQ-036 stall_ICache held 3 cycles at 0x1C000010 -> state MISS, addr held, o_is_valid=00 for 3 cycles, then a pair for 0x1C000010/14.
REQ-037 i_is_full=1 during RUN -> req=0, state HOLD, pc held; deassert -> RUN and fetch resumes at the same pc.
REQ-038 flush_BR, stall_ICache and i_is_full all asserted in HOLD -> RUN at the target address; rst during MISS -> BOOT with pc=RESET_PC.
REQ-039 pc=0xFFFFFFF8 pair fire -> o_PC2=0xFFFFFFFC and next fetch addr 0x00000000.
